// File: rtl/tomasulo_cdb_sch.sv
// CDB writeback slot scheduler: books a future bus slot per grant and drives the
// source-mux select for the slot reaching the bus this cycle.
module tomasulo_cdb_sch #(
    parameter int M         = 3,
    parameter int DEPTH     = 4,
    parameter int LAT [M]   = '{1, 2, 3}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M-1:0]         cdb_req,
    output logic [M-1:0]         cdb_gnt,
    output logic [DEPTH:0]       sch_r,
    output logic                 cdb_sel_vld,
    output logic [$clog2(M)-1:0] cdb_sel
);
    localparam int PW = $clog2(M);

    if (M < 2) begin : g_bad_m
        $error("tomasulo_cdb_sch: M must be at least 2");
    end
    for (genvar g = 0; g < M; g++) begin : g_lat_chk
        if (LAT[g] < 1 || LAT[g] > DEPTH) begin : g_bad_lat
            $error("tomasulo_cdb_sch: LAT out of range 1..DEPTH");
        end
    end

    logic [DEPTH:0]         sch_q, sch_d;
    logic [DEPTH:0][PW-1:0] own_q, own_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [DEPTH:1]         book;
    logic [DEPTH:1][PW-1:0] book_own;

    // Round-robin scan; one winner per latency, distinct latencies may all win.
    always_comb begin
        int  idx;
        int  first;
        logic found;
        logic [DEPTH:0] used;
        cdb_gnt = '0;
        used    = '0;
        found   = 1'b0;
        first   = 0;
        idx     = 0;
        for (int s = 0; s < M; s++) begin
            idx = (int'(ptr_q) + s) % M;
            if (!rst && cdb_req[idx] && !sch_q[LAT[idx]] && !used[LAT[idx]]) begin
                cdb_gnt[idx]  = 1'b1;
                used[LAT[idx]] = 1'b1;
                if (!found) begin
                    found = 1'b1;
                    first = idx;
                end
            end
        end
        ptr_d = found ? PW'((first + 1) % M) : ptr_q;
    end

    always_comb begin
        book     = '0;
        book_own = '0;
        for (int i = 0; i < M; i++) begin
            if (cdb_gnt[i]) begin
                book[LAT[i]]     = 1'b1;
                book_own[LAT[i]] = PW'(i);
            end
        end
        sch_d        = '0;
        own_d        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sch_d[k] = sch_q[k+1] | book[k+1];
            own_d[k] = book[k+1] ? book_own[k+1] : own_q[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sch_q <= '0;
            own_q <= '0;
            ptr_q <= '0;
        end else begin
            sch_q <= sch_d;
            own_q <= own_d;
            ptr_q <= ptr_d;
        end
    end

    assign sch_r       = sch_q;
    assign cdb_sel_vld = sch_q[0];
    assign cdb_sel     = own_q[0];
endmodule
